// File: rtl/zigzag_buf_if.sv
// Handshake bundle between the quantizer, the zigzag reorder buffer and the entropy coder.
// The master side drives samples in and accepts words out; the slave side is the buffer.
interface zigzag_buf_if #(
  parameter int DW = 9
);
  logic          in_valid;
  logic [DW-1:0] dctq_in;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sob;
  logic          out_eob;
  logic          ovf;

  modport master (
    output in_valid, dctq_in, out_ready,
    input  in_ready, out_valid, out_data, out_sob, out_eob, ovf
  );

  modport slave (
    input  in_valid, dctq_in, out_ready,
    output in_ready, out_valid, out_data, out_sob, out_eob, ovf
  );
endinterface

// File: rtl/zigzag_buf.sv
// Ping-pong 8x8 reorder buffer: raster-order coefficients in, JPEG zigzag order out.
// Define ZZ_EOB_EN to stop each block after its last nonzero zigzag coefficient.
module zigzag_buf #(
  parameter int DW = 9
) (
  input  logic        clk,
  input  logic        rst,
  zigzag_buf_if.slave bus
);

  // Zigzag index of each raster position r = 8*row + col.
  localparam logic [5:0] ZZ_OF_RASTER [64] = '{
    6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
    6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
    6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
    6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
    6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
    6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
    6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
    6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
  };

  logic [DW-1:0] mem_q [128];

  logic [5:0]    wr_cnt_q, wr_cnt_d;
  logic [5:0]    rd_cnt_q, rd_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_sob_q, out_sob_d;
  logic          out_eob_q, out_eob_d;
  logic          ovf_q, ovf_d;

  logic          in_ready;
  logic          accept;
  logic          load;
  logic          rd_last;
  logic [5:0]    wr_zz;

  assign in_ready = !full_q[wr_bank_q];
  assign accept   = bus.in_valid & in_ready;
  assign load     = full_q[rd_bank_q] & (!out_valid_q | bus.out_ready);
  assign wr_zz    = ZZ_OF_RASTER[wr_cnt_q];

`ifdef ZZ_EOB_EN
  logic [1:0][5:0] last_nz_q, last_nz_d;
  logic [5:0]      nz_base;

  // Raster 0 restarts the running maximum, so stale bank history never leaks in.
  always_comb begin
    last_nz_d = last_nz_q;
    nz_base   = (wr_cnt_q == 6'd0) ? 6'd0 : last_nz_q[wr_bank_q];
    if (accept) begin
      if ((bus.dctq_in != '0) && (wr_zz > nz_base)) last_nz_d[wr_bank_q] = wr_zz;
      else                                          last_nz_d[wr_bank_q] = nz_base;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last_nz_q <= '0;
    else     last_nz_q <= last_nz_d;
  end

  assign rd_last = (rd_cnt_q == last_nz_q[rd_bank_q]);
`else
  assign rd_last = &rd_cnt_q;
`endif

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sob_d   = out_sob_q;
    out_eob_d   = out_eob_q;
    ovf_d       = ovf_q | (bus.in_valid & !in_ready);

    if (accept) begin
      if (&wr_cnt_q) begin
        wr_cnt_d         = 6'd0;
        wr_bank_d        = ~wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 6'd1;
      end
    end

    // Set and clear always target different banks: a full bank is never written.
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[{rd_bank_q, rd_cnt_q}];
      out_sob_d   = (rd_cnt_q == 6'd0);
      out_eob_d   = rd_last;
      if (rd_last) begin
        rd_cnt_d          = 6'd0;
        rd_bank_d         = ~rd_bank_q;
        full_d[rd_bank_q] = 1'b0;
      end else begin
        rd_cnt_d = rd_cnt_q + 6'd1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sob_q   <= 1'b0;
      out_eob_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sob_q   <= out_sob_d;
      out_eob_q   <= out_eob_d;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: the coefficient storage has no reset; the full flags guarantee it is written before read.
  always_ff @(posedge clk) begin
    if (accept) mem_q[{wr_bank_q, wr_zz}] <= bus.dctq_in;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sob   = out_sob_q;
  assign bus.out_eob   = out_eob_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_zigzag_buf.sv
// Directed self-checking bench for zigzag_buf; expectations adapt when ZZ_EOB_EN is defined.
module tb_zigzag_buf;

  localparam int DW = 9;

  // Raster position of each zigzag index (scan order).
  localparam int ZZ_RASTER [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sob;
    logic          eob;
  } word_t;

  logic clk;
  logic rst;
  zigzag_buf_if #(.DW(DW)) bus ();

  zigzag_buf #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] blk [64];
  word_t         got_q [$];
  word_t         exp_q [$];
  logic          stall_prev = 1'b0;
  word_t         stall_word;
  logic          saw_not_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Collect accepted words and verify that stalled outputs hold stable.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_hold", {bus.out_data, bus.out_sob, bus.out_eob}, stall_word);
      end
      if (!bus.in_ready) saw_not_ready = 1'b1;
      if (bus.out_valid && bus.out_ready)
        got_q.push_back('{data: bus.out_data, sob: bus.out_sob, eob: bus.out_eob});
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_word = '{data: bus.out_data, sob: bus.out_sob, eob: bus.out_eob};
    end
  end

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  // Append the expected output words of the current blk contents.
  task automatic build_exp();
    int cnt;
    cnt = 64;
`ifdef ZZ_EOB_EN
    cnt = 1;
    for (int k = 0; k < 64; k++) if (blk[ZZ_RASTER[k]] != '0) cnt = k + 1;
`endif
    for (int k = 0; k < cnt; k++)
      exp_q.push_back('{data: blk[ZZ_RASTER[k]], sob: (k == 0), eob: (k == cnt - 1)});
  endtask

  // Feed the first n raster samples of blk, never offering a sample while in_ready is low.
  task automatic feed(input int n);
    int wait_n;
    for (int r = 0; r < n; r++) begin
      wait_n = 0;
      while (!bus.in_ready && wait_n < 3000) begin
        bus.in_valid = 1'b0;
        tick();
        wait_n++;
      end
      if (wait_n >= 3000) begin
        check("in_ready_timeout", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        return;
      end
      bus.in_valid = 1'b1;
      bus.dctq_in  = blk[r];
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int t;
    t = 0;
    bus.out_ready = 1'b1;
    while (got_q.size() < n && t < 3000) begin
      tick();
      t++;
    end
    check("word_count", got_q.size(), n);
  endtask

  task automatic compare_all(input string name);
    word_t g, e;
    int    k;
    wait_words(exp_q.size());
    k = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check($sformatf("%s[%0d].data", name, k), g.data, e.data);
      check($sformatf("%s[%0d].sob", name, k), g.sob, e.sob);
      check($sformatf("%s[%0d].eob", name, k), g.eob, e.eob);
      k++;
    end
    repeat (4) tick();
    check({name, "_extra_words"}, got_q.size(), 0);
    got_q.delete();
    exp_q.delete();
  endtask

  // With out_ready high, out_valid must stay high for n consecutive cycles.
  task automatic stream_check(input string name, input int n);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_valid[%0d]", name, i), bus.out_valid, 1);
      tick();
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_out_valid"}, bus.out_valid, 0);
    check({name, "_out_data"}, bus.out_data, 0);
    check({name, "_out_sob"}, bus.out_sob, 0);
    check({name, "_out_eob"}, bus.out_eob, 0);
    check({name, "_ovf"}, bus.ovf, 0);
    check({name, "_in_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.dctq_in   = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b0;

    // Reset values, then a partial block discarded by a second reset.
    do_reset();
    check_reset_state("rst1");
    for (int r = 0; r < 64; r++) blk[r] = DW'(200 + r);
    feed(30);
    do_reset();
    check_reset_state("rst2");

    // Ramp block: latency, hand-computed zigzag positions, framing.
    for (int r = 0; r < 64; r++) blk[r] = DW'(r + 1);
    build_exp();
    feed(64);
    check("lat_before", bus.out_valid, 0);
    tick();
    check("lat_valid", bus.out_valid, 1);
    check("lat_first_data", bus.out_data, 1);
    check("lat_first_sob", bus.out_sob, 1);
    wait_words(64);
    if (got_q.size() >= 64) begin
      check("ramp_idx1", got_q[1].data, 2);
      check("ramp_idx2", got_q[2].data, 9);
      check("ramp_idx3", got_q[3].data, 17);
      check("ramp_idx4", got_q[4].data, 10);
      check("ramp_idx5", got_q[5].data, 3);
      check("ramp_idx28", got_q[28].data, 8);
      check("ramp_idx35", got_q[35].data, 57);
      check("ramp_idx63", got_q[63].data, 64);
      check("ramp_idx1_sob", got_q[1].sob, 0);
      check("ramp_idx62_eob", got_q[62].eob, 0);
      check("ramp_idx63_eob", got_q[63].eob, 1);
    end
    compare_all("ramp");

    // Both banks fill, an overflow sample is dropped, then 128 words stream without a bubble.
    do_reset();
    bus.out_ready = 1'b0;
    for (int r = 0; r < 64; r++) blk[r] = DW'(r + 1);
    build_exp();
    feed(64);
    for (int r = 0; r < 64; r++) blk[r] = DW'(300 + r);
    build_exp();
    feed(64);
    check("full_in_ready", bus.in_ready, 0);
    check("full_ovf_before", bus.ovf, 0);
    bus.in_valid = 1'b1;
    bus.dctq_in  = DW'(5);
    tick();
    bus.in_valid = 1'b0;
    check("ovf_set", bus.ovf, 1);
    stream_check("b2b", 128);
    compare_all("b2b");
    check("ovf_sticky", bus.ovf, 1);

    // Continuous input against a downstream that accepts every other cycle.
    do_reset();
    saw_not_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          for (int r = 0; r < 64; r++) blk[r] = DW'(k * 37 + r * 5 + 1);
          build_exp();
          feed(64);
        end
      end
      begin
        for (int i = 0; i < 500; i++) begin
          bus.out_ready = ~bus.out_ready;
          tick();
        end
      end
    join
    compare_all("toggle");
    check("toggle_in_ready_dropped", saw_not_ready, 1);
    check("toggle_no_ovf", bus.ovf, 0);

    // Sparse block: one nonzero at raster 9 (zigzag index 4).
    do_reset();
    for (int r = 0; r < 64; r++) blk[r] = '0;
    blk[9] = 9'h1FD;
    build_exp();
    feed(64);
`ifdef ZZ_EOB_EN
    wait_words(5);
    if (got_q.size() >= 5) begin
      check("sparse_idx4", got_q[4].data, 9'h1FD);
      check("sparse_idx4_eob", got_q[4].eob, 1);
      check("sparse_idx3", got_q[3].data, 0);
    end
`else
    wait_words(64);
    if (got_q.size() >= 64) begin
      check("sparse_idx4", got_q[4].data, 9'h1FD);
      check("sparse_idx4_eob", got_q[4].eob, 0);
      check("sparse_idx63_eob", got_q[63].eob, 1);
    end
`endif
    compare_all("sparse");

    // All-zero block followed by a ramp block, drained without a bubble.
    do_reset();
    bus.out_ready = 1'b0;
    for (int r = 0; r < 64; r++) blk[r] = '0;
    build_exp();
    feed(64);
    for (int r = 0; r < 64; r++) blk[r] = DW'(r + 1);
    build_exp();
    feed(64);
`ifdef ZZ_EOB_EN
    check("zero_single_sob", bus.out_sob, 1);
    check("zero_single_eob", bus.out_eob, 1);
    stream_check("zero", 65);
`else
    check("zero_first_eob", bus.out_eob, 0);
    stream_check("zero", 128);
`endif
    compare_all("zero");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zigzag_buf.md
Name: zigzag_buf

Overview:
- Ping-pong reorder buffer directly downstream of the 12x8 quantizing multiplier.
- Collects 64 quantized DCT coefficients per 8x8 block, arriving in raster (row-major) order.
- Emits them in JPEG zigzag order over a valid/ready handshake to the entropy-coding stage.
- Two banks let one block be written while the previous one is read, giving sustained 1 coefficient/clk.

Parameters:
DW, 9, coefficient width (two's complement, matches dctq).

Ports:
clk        input   1   clock, all logic on rising edge
rst        input   1   synchronous, active-high reset
in_valid   input   1   dctq_in carries a coefficient this cycle
dctq_in    input   DW  quantized coefficient, raster order r = 8*row + col
in_ready   output  1   current write bank not full; sample is accepted when in_valid & in_ready
out_valid  output  1   out_data/out_sob/out_eob valid
out_ready  input   1   downstream accepts the word when out_valid & out_ready
out_data   output  DW  coefficient in zigzag order
out_sob    output  1   word is zigzag index 0 (DC)
out_eob    output  1   word is the last emitted word of the block
ovf        output  1   sticky: a sample arrived while in_ready=0

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sob=0, out_eob=0, ovf=0, in_ready=1. Also wr_cnt=rd_cnt=0, wr_bank=rd_bank=0, both full flags=0. Memory contents are not reset.
- Storage: two banks of 64xDW registers.
- Zigzag mapping: table zz(r) gives the standard JPEG zigzag index of raster position r. Examples: r0->0, r1->1, r8->2, r16->3, r9->4, r2->5, r7->28, r56->35, r63->63.
- Write side:
  - On accept, bank[wr_bank][zz(wr_cnt)] <= dctq_in and wr_cnt increments.
  - When wr_cnt==63 is accepted: full[wr_bank]<=1, wr_bank toggles, wr_cnt<=0.
  - in_ready = !full[wr_bank]. The multiplier cannot stall.
  - in_valid & !in_ready: sample is dropped, counters unchanged, ovf<=1 until rst.
- Read side:
  - The output register loads when full[rd_bank] & (!out_valid | out_ready). It loads out_data=bank[rd_bank][rd_cnt], out_sob=(rd_cnt==0), out_eob=(rd_cnt==last), where last=63 unless ZZ_EOB_EN is defined.
  - When the loaded word is the last one: full[rd_bank]<=0, rd_bank toggles, rd_cnt<=0. Otherwise rd_cnt increments.
  - If out_valid & out_ready and there is no load, out_valid<=0.
  - out_valid & !out_ready: all outputs hold stable.
- Latency: 64th sample accepted at edge E, so full is set at E. The first word (zz0) has out_valid high after edge E+1.
- Back-to-back blocks stream with no bubble.
- Simultaneous events: setting full on one bank and clearing it on the other in the same cycle are independent and both take effect.
- A bank can never be written and released in the same cycle, because writes into a full bank are blocked.
- rst mid-block discards partial and buffered blocks. The next accepted sample is treated as raster 0.

Optional Feature:
Macro ZZ_EOB_EN.
- Defined:
  - Each bank keeps last_nz[5:0], loaded with 0 on the accept of raster 0 of a block.
  - On every accept with dctq_in != 0, last_nz <= max(last_nz, zz(wr_cnt)). For raster 0 the comparison uses 0 as the old value.
  - Read stops after index last_nz: out_eob is set on that word, then the bank is released. Remaining zero coefficients are not emitted.
  - The DC word (index 0) is always emitted, even for an all-zero block.
- Undefined: all 64 words are emitted per block and out_eob is on index 63. No last_nz logic is present.

Test Plan:
1. Assert rst for 2 clk -> out_valid=0, out_data=0, ovf=0, in_ready=1. Repeat with rst asserted for 2 clk after 30 accepted samples, then feed one full block -> only that block is emitted, correctly ordered.
2. One block with dctq_in = r+1 (1..64), out_ready=1 -> out_data sequence 1,2,9,17,10,3,...; index 28 = 8, index 35 = 57, last = 64. out_sob on the first word only; out_eob on the 64th (macro undefined). The first word appears one edge after the 64th accept.
3. 128 samples with out_ready=0 -> in_ready=0 after the 128th. A 129th in_valid sets ovf=1 and the sample is lost. Then out_ready=1 -> 128 consecutive words (block 1 then block 2) with out_valid never dropping; ovf stays 1.
4. Continuous input with out_ready toggling 1/0 each cycle -> data held stable while stalled, no word lost or repeated, in_ready drops once both banks fill.
5. Block all zero except raster 9 = -3 (9'h1FD) -> ZZ_EOB_EN defined: exactly 5 words 0,0,0,0,1FD with out_eob on the 5th. Undefined: 64 words with 1FD at index 4 and out_eob at index 63.
6. All-zero block with ZZ_EOB_EN defined -> a single word 0 with out_sob=1 and out_eob=1. The next block follows on the following cycle.
